risc_z_ctrl_fsm: RTL and testbench

- Multi-cycle control FSM for the RISC-Z 16-bit CPU.
- Sequences fetch, decode, execute, memory and writeback over one shared memory port using a req/ack handshake.
- Drives the datapath enables, including sign_op for the sign extender: 0=imm10, 1=imm4, 2=imm6, 3=imm8.
- Sits between the instruction register, flags and memory interface on one side and the register file, ALU muxes and PC on the other.

---
 rtl/risc_z_ctrl_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_risc_z_ctrl_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/risc_z_ctrl_fsm.sv
// Multi-cycle control FSM for the RISC-Z 16-bit CPU.
// Sequences fetch/decode/exec/mem/writeback over one shared req/ack memory port
// and drives the datapath enables. Outputs are decoded from state and instr.
// Optional build macro: MEM_TIMEOUT_EN adds a memory wait watchdog and FAULT state.
module risc_z_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [1:0]  sign_op,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        illegal,
    output logic        halted,
    output logic        fault
);

    localparam logic [3:0] op_nop  = 4'h0;
    localparam logic [3:0] op_add  = 4'h1;
    localparam logic [3:0] op_addi = 4'h2;
    localparam logic [3:0] op_lw   = 4'h3;
    localparam logic [3:0] op_sw   = 4'h4;
    localparam logic [3:0] op_li   = 4'h5;
    localparam logic [3:0] op_beq  = 4'h6;
    localparam logic [3:0] op_jmp  = 4'h7;
    localparam logic [3:0] op_halt = 4'hF;

    typedef enum logic [2:0] {
        st_fetch,
        st_decode,
        st_exec,
        st_mem,
        st_wb,
`ifdef MEM_TIMEOUT_EN
        st_halt,
        st_fault
`else
        st_halt
`endif
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [3:0] opcode;
    logic [1:0] dec_sign;
    logic       dec_imm;
    logic       dec_illegal;
    logic       timeout_hit;

    assign opcode = instr[15:12];

    // Only the opcode steers the FSM; operand fields belong to the datapath.
    logic unused_bits;
    assign unused_bits = &{1'b0, instr[11:0], (TIMEOUT_CYCLES != 0)};

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
    logic [CW-1:0] wait_cnt;

    // Wait counter: cleared on any state change, counts unacknowledged request cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_n != state) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_fetch;
        end else begin
            state <= state_n;
        end
    end

    // Opcode decode: immediate format, ALU B source and legality.
    always_comb begin
        dec_sign    = 2'd0;
        dec_imm     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            op_nop, op_add, op_jmp, op_halt: ;
            op_addi: begin dec_sign = 2'd1; dec_imm = 1'b1; end
            op_lw:   begin dec_sign = 2'd2; dec_imm = 1'b1; end
            op_sw:   begin dec_sign = 2'd2; dec_imm = 1'b1; end
            op_li:   begin dec_sign = 2'd3; dec_imm = 1'b1; end
            op_beq:  dec_sign = 2'd3;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next-state and output decode; reset forces every output low.
    always_comb begin
        state_n     = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        sign_op     = 2'd0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (state)
            st_fetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_n = st_decode;
                end else if (timeout_hit) begin
`ifdef MEM_TIMEOUT_EN
                    state_n = st_fault;
`endif
                end
            end
            st_decode: begin
                sign_op     = dec_sign;
                alu_src_imm = dec_imm;
                illegal     = dec_illegal;
                state_n     = st_exec;
            end
            st_exec: begin
                sign_op     = dec_sign;
                alu_src_imm = dec_imm;
                case (opcode)
                    op_add, op_addi, op_li: state_n = st_wb;
                    op_lw, op_sw:           state_n = st_mem;
                    op_jmp: begin
                        pc_we   = 1'b1;
                        pc_src  = 1'b1;
                        state_n = st_fetch;
                    end
                    op_beq: begin
                        pc_we   = zero;
                        pc_src  = 1'b1;
                        state_n = st_fetch;
                    end
                    op_halt: state_n = st_halt;
                    default: state_n = st_fetch;
                endcase
            end
            st_mem: begin
                mem_req     = 1'b1;
                addr_sel    = 1'b1;
                mem_we      = (opcode == op_sw);
                sign_op     = dec_sign;
                alu_src_imm = dec_imm;
                if (mem_ack) begin
                    state_n = (opcode == op_lw) ? st_wb : st_fetch;
                end else if (timeout_hit) begin
`ifdef MEM_TIMEOUT_EN
                    state_n = st_fault;
`endif
                end
            end
            st_wb: begin
                reg_we      = 1'b1;
                wb_sel      = (opcode == op_lw);
                sign_op     = dec_sign;
                alu_src_imm = dec_imm;
                state_n     = st_fetch;
            end
            st_halt: halted = 1'b1;
`ifdef MEM_TIMEOUT_EN
            st_fault: fault = 1'b1;
`endif
            default: state_n = st_fetch;
        endcase
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 1'b0;
            sign_op     = 2'd0;
            alu_src_imm = 1'b0;
            reg_we      = 1'b0;
            wb_sel      = 1'b0;
            illegal     = 1'b0;
            halted      = 1'b0;
            fault       = 1'b0;
        end
    end

endmodule

// File: tb/tb_risc_z_ctrl_fsm.sv
// Table-driven bench for risc_z_ctrl_fsm: one vector per clock cycle.
module tb_risc_z_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
    logic [1:0]  sign_op;
    logic        alu_src_imm, reg_we, wb_sel, illegal, halted, fault;

    int checks = 0;
    int errors = 0;

    // Output bit positions in the packed expectation word.
    localparam logic [13:0] REQ  = 14'h2000;
    localparam logic [13:0] WE   = 14'h1000;
    localparam logic [13:0] ASEL = 14'h0800;
    localparam logic [13:0] IRW  = 14'h0400;
    localparam logic [13:0] PCW  = 14'h0200;
    localparam logic [13:0] PCS  = 14'h0100;
    localparam logic [13:0] SO1  = 14'h0040;
    localparam logic [13:0] SO2  = 14'h0080;
    localparam logic [13:0] SO3  = 14'h00C0;
    localparam logic [13:0] IMM  = 14'h0020;
    localparam logic [13:0] RWE  = 14'h0010;
    localparam logic [13:0] WBS  = 14'h0008;
    localparam logic [13:0] ILL  = 14'h0004;
    localparam logic [13:0] HLT  = 14'h0002;
    localparam logic [13:0] FLT  = 14'h0001;
    localparam logic [13:0] NONE = 14'h0000;
    localparam logic [13:0] FA   = REQ | IRW | PCW;

    typedef struct {
        logic        rst;
        logic [15:0] instr;
        logic        zero;
        logic        ack;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    risc_z_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .sign_op(sign_op), .alu_src_imm(alu_src_imm),
        .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .halted(halted), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [15:0] i, input logic z,
                       input logic a, input logic [13:0] e);
        vec_t v;
        v.rst = r; v.instr = i; v.zero = z; v.ack = a; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [13:0] got;

        // Reset held with ack high: everything low.
        for (int k = 0; k < 3; k++) add(1, 16'h0000, 0, 1, NONE);
        // ADDI, zero-wait: reg_we in cycle 4.
        add(0, 16'h2AB6, 0, 1, FA);
        add(0, 16'h2AB6, 0, 0, SO1 | IMM);
        add(0, 16'h2AB6, 0, 0, SO1 | IMM);
        add(0, 16'h2AB6, 0, 0, SO1 | IMM | RWE);
        // LW with two MEM wait cycles; ack in DECODE must be ignored.
        add(0, 16'h3A5D, 0, 1, FA);
        add(0, 16'h3A5D, 0, 1, SO2 | IMM);
        add(0, 16'h3A5D, 0, 0, SO2 | IMM);
        add(0, 16'h3A5D, 0, 0, REQ | ASEL | SO2 | IMM);
        add(0, 16'h3A5D, 0, 0, REQ | ASEL | SO2 | IMM);
        add(0, 16'h3A5D, 0, 1, REQ | ASEL | SO2 | IMM);
        add(0, 16'h3A5D, 0, 0, SO2 | IMM | RWE | WBS);
        // SW with one fetch wait cycle.
        add(0, 16'h4123, 0, 0, REQ);
        add(0, 16'h4123, 0, 1, FA);
        add(0, 16'h4123, 0, 0, SO2 | IMM);
        add(0, 16'h4123, 0, 0, SO2 | IMM);
        add(0, 16'h4123, 0, 1, REQ | ASEL | WE | SO2 | IMM);
        // BEQ taken then not taken.
        add(0, 16'h6125, 1, 1, FA);
        add(0, 16'h6125, 1, 0, SO3);
        add(0, 16'h6125, 1, 0, SO3 | PCW | PCS);
        add(0, 16'h6125, 0, 1, FA);
        add(0, 16'h6125, 0, 0, SO3);
        add(0, 16'h6125, 0, 0, SO3 | PCS);
        // JMP.
        add(0, 16'h7123, 0, 1, FA);
        add(0, 16'h7123, 0, 0, NONE);
        add(0, 16'h7123, 0, 0, PCW | PCS);
        // ADD.
        add(0, 16'h1234, 0, 1, FA);
        add(0, 16'h1234, 0, 0, NONE);
        add(0, 16'h1234, 0, 0, NONE);
        add(0, 16'h1234, 0, 0, RWE);
        // LI.
        add(0, 16'h5011, 0, 1, FA);
        add(0, 16'h5011, 0, 0, SO3 | IMM);
        add(0, 16'h5011, 0, 0, SO3 | IMM);
        add(0, 16'h5011, 0, 0, SO3 | IMM | RWE);
        // NOP.
        add(0, 16'h0000, 0, 1, FA);
        add(0, 16'h0000, 0, 0, NONE);
        add(0, 16'h0000, 0, 0, NONE);
        // Illegal opcode: one-cycle pulse in DECODE.
        add(0, 16'hA000, 0, 1, FA);
        add(0, 16'hA000, 0, 0, ILL);
        add(0, 16'hA000, 0, 0, NONE);
        // Reset in the middle of a fetch handshake.
        add(0, 16'h3A5D, 0, 0, REQ);
        add(1, 16'h3A5D, 0, 1, NONE);
        // Reset in the middle of a MEM handshake.
        add(0, 16'h3A5D, 0, 1, FA);
        add(0, 16'h3A5D, 0, 0, SO2 | IMM);
        add(0, 16'h3A5D, 0, 0, SO2 | IMM);
        add(0, 16'h3A5D, 0, 0, REQ | ASEL | SO2 | IMM);
        add(1, 16'h3A5D, 0, 1, NONE);
        add(0, 16'hF000, 0, 0, REQ);
        // HALT absorbs acks until reset.
        add(0, 16'hF000, 0, 1, FA);
        add(0, 16'hF000, 0, 0, NONE);
        add(0, 16'hF000, 0, 0, NONE);
        for (int k = 0; k < 20; k++) add(0, 16'hF000, 0, 1, HLT);
        add(1, 16'hF000, 0, 1, NONE);
        add(0, 16'h0000, 0, 0, REQ);
`ifdef MEM_TIMEOUT_EN
        // Fetch timeout after four unacknowledged cycles.
        add(1, 16'hA000, 0, 0, NONE);
        for (int k = 0; k < 4; k++) add(0, 16'hA000, 0, 0, REQ);
        add(0, 16'hA000, 0, 0, FLT);
        for (int k = 0; k < 3; k++) add(0, 16'hA000, 0, 1, FLT);
        // Ack on the fourth wait cycle wins over the timeout.
        add(1, 16'hA000, 0, 0, NONE);
        for (int k = 0; k < 3; k++) add(0, 16'hA000, 0, 0, REQ);
        add(0, 16'hA000, 0, 1, FA);
        add(0, 16'hA000, 0, 0, ILL);
        add(0, 16'hA000, 0, 0, NONE);
        add(0, 16'hA000, 0, 0, REQ);
`endif

        for (int n = 0; n < vecs.size(); n++) begin
            rst     = vecs[n].rst;
            instr   = vecs[n].instr;
            zero    = vecs[n].zero;
            mem_ack = vecs[n].ack;
            @(negedge clk);
            got = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, sign_op,
                   alu_src_imm, reg_we, wb_sel, illegal, halted, fault};
            checks++;
            if (got !== vecs[n].exp) begin
                errors++;
                $display("FAIL vec%0d outputs got %b want %b (req,we,asel,irw,pcw,pcs,so,imm,rwe,wbs,ill,hlt,flt)",
                         n, got, vecs[n].exp);
            end
            checks++;
            if (pc_we && reg_we) begin
                errors++;
                $display("FAIL vec%0d pc_we_reg_we_exclusive got %b%b want not both 1", n, pc_we, reg_we);
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
